// File: rtl/regfile_dump_reader.sv
// Sequential read-out engine: walks the register file two registers at a time and
// streams each snapshotted value over a valid/ready port tagged with its index.
module regfile_dump_reader #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5
) (
   input  logic              clock_in,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] readReg1,
   output logic [ADDR_W-1:0] readReg2,
   input  logic [31:0]       readData1,
   input  logic [31:0]       readData2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic [ADDR_W-1:0] out_index,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      SEND0 = 3'd2,
      SEND1 = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   state_t            state_r;
   logic [ADDR_W-2:0] pairCnt_r;
   logic [31:0]       buf1_r;
   logic [ADDR_W-2:0] pairNext_s;

   // Index of the pair that follows the one currently being sent.
   assign pairNext_s = pairCnt_r + {{(ADDR_W-2){1'b0}}, 1'b1};

   // Dump sequencer; out_data doubles as the even-word snapshot buffer.
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         pairCnt_r <= {(ADDR_W-1){1'b0}};
         buf1_r    <= 32'h0000_0000;
         readReg1  <= {ADDR_W{1'b0}};
         readReg2  <= {ADDR_W{1'b0}};
         out_valid <= 1'b0;
         out_data  <= 32'h0000_0000;
         out_index <= {ADDR_W{1'b0}};
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state_r   <= READ;
                  pairCnt_r <= {(ADDR_W-1){1'b0}};
                  readReg1  <= {ADDR_W{1'b0}};
                  readReg2  <= {{(ADDR_W-1){1'b0}}, 1'b1};
                  busy      <= 1'b1;
               end else begin
                  readReg1 <= {ADDR_W{1'b0}};
                  readReg2 <= {ADDR_W{1'b0}};
                  busy     <= 1'b0;
               end
            end
            READ: begin
               out_data  <= readData1;
               buf1_r    <= readData2;
               out_index <= readReg1;
               out_valid <= 1'b1;
               state_r   <= SEND0;
            end
            SEND0: begin
               if (out_ready) begin
                  out_data  <= buf1_r;
                  out_index <= readReg2;
                  state_r   <= SEND1;
               end else begin
                  state_r <= SEND0;
               end
            end
            SEND1: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (readReg2 == LAST_IDX) begin
                     state_r <= DONE;
                     done    <= 1'b1;
                  end else begin
                     pairCnt_r <= pairNext_s;
                     readReg1  <= {pairNext_s, 1'b0};
                     readReg2  <= {pairNext_s, 1'b1};
                     state_r   <= READ;
                  end
               end else begin
                  state_r <= SEND1;
               end
            end
            DONE: begin
               done     <= 1'b0;
               busy     <= 1'b0;
               readReg1 <= {ADDR_W{1'b0}};
               readReg2 <= {ADDR_W{1'b0}};
               state_r  <= IDLE;
            end
            default: begin
               state_r   <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
               readReg1  <= {ADDR_W{1'b0}};
               readReg2  <= {ADDR_W{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: a register file model feeds the read
// ports, expected words are queued at stimulus time and popped on each transfer.
module tb_regfile_dump_reader;
   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;

   logic              clock_in = 1'b0;
   logic              reset;
   logic              start;
   logic              out_ready;
   logic [ADDR_W-1:0] readReg1, readReg2, out_index;
   logic [31:0]       readData1, readData2, out_data;
   logic              out_valid, busy, done;

   logic [31:0] rf [NUM_REGS];
   assign readData1 = rf[readReg1];
   assign readData2 = rf[readReg2];

   typedef struct packed {
      logic [4:0]  idx;
      logic [31:0] data;
   } word_t;

   word_t expQ[$];
   word_t popW;
   int    doneCyc[$];
   int    cyc = 0, passCnt = 0, checkCnt = 0, wordCnt = 0, doneCnt = 0;
   int    lastDoneCyc = -1, lastXferEdge = -1;
   int    stallLeft = 0, writeCyc = -1, e0 = 0;
   bit    pokeStart = 1'b0;

   regfile_dump_reader #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
      .clock_in(clock_in), .reset(reset), .start(start),
      .readReg1(readReg1), .readReg2(readReg2),
      .readData1(readData1), .readData2(readData2),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_index(out_index),
      .busy(busy), .done(done)
   );

   always #5 clock_in = ~clock_in;

   always @(posedge clock_in) cyc <= cyc + 1;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCnt++;
      if (got === exp) passCnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Transfers are judged half a cycle before the edge that completes them.
   always @(negedge clock_in) begin
      if (out_valid && out_ready) begin
         if (expQ.size() == 0) begin
            checkVal("word with empty scoreboard", 32'(expQ.size()), 32'd1);
         end else begin
            popW = expQ.pop_front();
            checkVal("out_index", {27'b0, out_index}, {27'b0, popW.idx});
            checkVal("out_data", out_data, popW.data);
         end
         wordCnt++;
         lastXferEdge = cyc + 1;
      end else if (out_valid && !out_ready && expQ.size() > 0) begin
         checkVal("hold index", {27'b0, out_index}, {27'b0, expQ[0].idx});
         checkVal("hold data", out_data, expQ[0].data);
      end
      if (done) begin
         doneCnt++;
         lastDoneCyc = cyc;
         doneCyc.push_back(cyc);
      end
   end

   task automatic step();
      @(posedge clock_in);
      #1;
      if (stallLeft > 0 && out_valid && out_index == 5'd10) begin
         out_ready = 1'b0;
         stallLeft--;
      end else begin
         out_ready = 1'b1;
      end
      if (pokeStart) start = out_valid && (out_index == 5'd5 || out_index == 5'd17);
      if (cyc == writeCyc) begin
         rf[3]  = 32'h1234_5678;
         rf[20] = 32'hA5A5_A5A5;
      end
   endtask

   task automatic pushDump(input int snapIdx, input logic [31:0] snapVal);
      word_t w;
      for (int i = 0; i < NUM_REGS; i++) begin
         w.idx  = 5'(i);
         w.data = (i == snapIdx) ? snapVal : rf[i];
         expQ.push_back(w);
      end
   endtask

   task automatic kickStart(input bit hold);
      @(posedge clock_in);
      #1;
      e0    = cyc + 1;
      start = 1'b1;
      if (!hold) begin
         step();
         start = 1'b0;
      end
   endtask

   task automatic waitDone(input int budget, input int expDone, input string tag);
      int n;
      int d0;
      n  = 0;
      d0 = doneCnt;
      while (doneCnt == d0 && n < budget) begin
         step();
         n++;
      end
      checkVal({tag, " done count"}, 32'(doneCnt - d0), 32'd1);
      checkVal({tag, " done cycle"}, 32'(lastDoneCyc), 32'(expDone));
      checkVal({tag, " busy after"}, {31'b0, busy}, 32'd0);
      checkVal({tag, " scoreboard drained"}, 32'(expQ.size()), 32'd0);
   endtask

   initial begin
      int w0, d0, n, base;
      reset = 1'b1;
      start = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) rf[i] = 32'h0;
      rf[21] = 32'hFFFF_0000;
      rf[10] = 32'h0000_FFFF;
      repeat (3) @(posedge clock_in);
      #1;
      checkVal("reset out_valid", {31'b0, out_valid}, 32'd0);
      checkVal("reset busy", {31'b0, busy}, 32'd0);
      checkVal("reset done", {31'b0, done}, 32'd0);
      checkVal("reset readReg2", {27'b0, readReg2}, 32'd0);
      checkVal("reset out_data", out_data, 32'd0);
      reset = 1'b0;
      step();

      // Basic dump with free-flowing consumer
      w0 = wordCnt;
      pushDump(-1, 32'h0);
      kickStart(1'b0);
      waitDone(80, e0 + 48, "basic");
      checkVal("basic word count", 32'(wordCnt - w0), 32'd32);
      checkVal("basic last transfer edge", 32'(lastXferEdge), 32'(e0 + 48));
      d0 = doneCnt;
      repeat (4) step();
      checkVal("basic single done pulse", 32'(doneCnt - d0), 32'd0);

      // Five cycles of backpressure on index 10
      w0 = wordCnt;
      stallLeft = 5;
      pushDump(-1, 32'h0);
      kickStart(1'b0);
      waitDone(90, e0 + 53, "stall");
      checkVal("stall word count", 32'(wordCnt - w0), 32'd32);
      checkVal("stall consumed", 32'(stallLeft), 32'd0);
      repeat (2) step();

      // Snapshot: reg3 written after its capture, reg20 before its capture
      w0 = wordCnt;
      pushDump(20, 32'hA5A5_A5A5);
      kickStart(1'b0);
      writeCyc = e0 + 6;
      waitDone(80, e0 + 48, "snapshot");
      checkVal("snapshot word count", 32'(wordCnt - w0), 32'd32);
      writeCyc = -1;
      rf[3] = 32'h0;
      rf[20] = 32'h0;
      repeat (2) step();

      // start pulses mid-dump are ignored
      w0 = wordCnt;
      pokeStart = 1'b1;
      pushDump(-1, 32'h0);
      kickStart(1'b0);
      waitDone(80, e0 + 48, "midstart");
      pokeStart = 1'b0;
      start = 1'b0;
      d0 = doneCnt;
      repeat (5) step();
      checkVal("midstart word count", 32'(wordCnt - w0), 32'd32);
      checkVal("midstart no restart", {31'b0, busy}, 32'd0);
      checkVal("midstart no extra done", 32'(doneCnt - d0), 32'd0);

      // Async reset while index 7 is on the port
      pushDump(-1, 32'h0);
      kickStart(1'b0);
      n = 0;
      while (!(out_valid && out_index == 5'd7) && n < 60) begin
         step();
         n++;
      end
      checkVal("abort reached index 7", {27'b0, out_index}, 32'd7);
      #2;
      reset = 1'b1;
      #1;
      checkVal("abort out_valid", {31'b0, out_valid}, 32'd0);
      checkVal("abort busy", {31'b0, busy}, 32'd0);
      checkVal("abort out_data", out_data, 32'd0);
      checkVal("abort readReg1", {27'b0, readReg1}, 32'd0);
      checkVal("abort readReg2", {27'b0, readReg2}, 32'd0);
      expQ.delete();
      d0 = doneCnt;
      repeat (2) step();
      reset = 1'b0;
      step();
      checkVal("abort no done", 32'(doneCnt - d0), 32'd0);
      w0 = wordCnt;
      pushDump(-1, 32'h0);
      kickStart(1'b0);
      waitDone(80, e0 + 48, "restart");
      checkVal("restart word count", 32'(wordCnt - w0), 32'd32);

      // start held high: back-to-back dumps
      w0 = wordCnt;
      base = doneCyc.size();
      pushDump(-1, 32'h0);
      pushDump(-1, 32'h0);
      kickStart(1'b1);
      n = 0;
      while (cyc < e0 + 102 && n < 120) begin
         step();
         n++;
         if (cyc == e0 + 49) checkVal("b2b busy gap", {31'b0, busy}, 32'd0);
         if (cyc == e0 + 50) begin
            checkVal("b2b busy restart", {31'b0, busy}, 32'd1);
            start = 1'b0;
         end
      end
      checkVal("b2b word count", 32'(wordCnt - w0), 32'd64);
      checkVal("b2b done count", 32'(doneCyc.size() - base), 32'd2);
      if (doneCyc.size() - base == 2) begin
         checkVal("b2b first done", 32'(doneCyc[base]), 32'(e0 + 48));
         checkVal("b2b second done", 32'(doneCyc[base + 1]), 32'(e0 + 98));
      end
      checkVal("b2b scoreboard drained", 32'(expQ.size()), 32'd0);
      checkVal("b2b idle after", {31'b0, busy}, 32'd0);

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end
endmodule
